softusb_ioevent: RTL and testbench

Microcontroller-side I/O peripheral of the SoftUSB core, in the USB clock domain. It decodes the navre I/O bus and gives firmware three things: an IRQ toggle for the host, a 16-entry event-byte FIFO drained by the host side, and a latched 16-bit free-running timer. It is the USB-end counterpart of the host interface. The host interface synchronizes `irq_flip` and the FIFO drain port into the system domain; that crossing is outside this block.

---
 rtl/softusb_ioevent.sv | 119 +++++++++++
 tb/tb_softusb_ioevent.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/softusb_ioevent.sv
// USB-domain I/O peripheral for the navre core. It provides a host IRQ toggle,
// an event-byte FIFO that the host drains, and a 16-bit timer with a latched high byte.
module softusb_ioevent #(
    parameter int fifo_depth_log2 = 4
) (
    input  logic       usb_clk,
    input  logic       usb_rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [5:0] io_a,
    input  logic [7:0] io_di,
    output logic [7:0] io_do,
    output logic       irq_flip,
    input  logic       evt_re,
    output logic [7:0] evt_dat,
    output logic       evt_empty
);
    localparam int DEPTH = 1 << fifo_depth_log2;
    localparam int CW    = fifo_depth_log2 + 1;
    localparam int PW    = fifo_depth_log2;

    localparam logic [5:0] A_IRQ   = 6'h15;
    localparam logic [5:0] A_PUSH  = 6'h16;
    localparam logic [5:0] A_STAT  = 6'h17;
    localparam logic [5:0] A_TMRL  = 6'h18;
    localparam logic [5:0] A_TMRH  = 6'h19;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;
    logic [15:0]   timer_q;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    io_do_q, io_do_d;

    logic full, empty, wr_irq, wr_push, wr_clr, pop, push_ok, ovf_set;
    logic [7:0] status;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_irq  = io_we && (io_a == A_IRQ);
    assign wr_push = io_we && (io_a == A_PUSH);
    assign wr_clr  = io_we && (io_a == A_STAT) && io_di[2];

    // A pop frees a slot in the same edge, so a full FIFO accepts a coincident push.
    assign pop     = evt_re && !empty;
    assign push_ok = wr_push && (!full || pop);
    assign ovf_set = wr_push && full && !pop;

    assign status  = 8'({count_q, ovf_q, full, empty});

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (ovf_set)     ovf_d = 1'b1;
        else if (wr_clr) ovf_d = 1'b0;
    end

    // Auto-notify: a push into an empty FIFO raises an IRQ without a firmware toggle.
    assign irq_d = irq_q ^ (wr_irq | (wr_push & empty));

    always_comb begin
        io_do_d  = 8'h00;
        shadow_d = shadow_q;
        if (io_re) begin
            case (io_a)
                A_STAT:  io_do_d = status;
                A_TMRL: begin
                    io_do_d  = timer_q[7:0];
                    shadow_d = timer_q[15:8];
                end
                A_TMRH:  io_do_d = shadow_q;
                default: io_do_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge usb_clk) begin
        if (usb_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            timer_q  <= 16'h0000;
            shadow_q <= 8'h00;
            io_do_q  <= 8'h00;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            timer_q  <= timer_q + 16'd1;
            shadow_q <= shadow_d;
            io_do_q  <= io_do_d;
        end
    end

    // Storage carries no reset; pointer reset alone discards the contents.
    always_ff @(posedge usb_clk) begin
        if (push_ok && !usb_rst) mem[wr_ptr_q] <= io_di;
    end

    assign io_do     = io_do_q;
    assign irq_flip  = irq_q;
    assign evt_dat   = mem[rd_ptr_q];
    assign evt_empty = empty;
endmodule

// File: tb/tb_softusb_ioevent.sv
// Scoreboard bench for softusb_ioevent: stimulus queues expected post-edge values,
// a monitor pops and compares them one step after each rising edge.
module tb_softusb_ioevent;
    logic       usb_clk = 1'b0;
    logic       usb_rst = 1'b1;
    logic       io_re = 1'b0, io_we = 1'b0, evt_re = 1'b0;
    logic [5:0] io_a = 6'h00;
    logic [7:0] io_di = 8'h00;
    logic [7:0] io_do, evt_dat;
    logic       irq_flip, evt_empty;

    softusb_ioevent #(.fifo_depth_log2(4)) dut (
        .usb_clk(usb_clk), .usb_rst(usb_rst),
        .io_re(io_re), .io_we(io_we), .io_a(io_a), .io_di(io_di), .io_do(io_do),
        .irq_flip(irq_flip),
        .evt_re(evt_re), .evt_dat(evt_dat), .evt_empty(evt_empty)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        int         due;
        int         kind;   // 0 io_do, 1 irq_flip, 2 evt_empty, 3 evt_dat
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rel_cyc = 0;

    always @(posedge usb_clk) cyc <= cyc + 1;

    always begin : monitor
        exp_t       e;
        logic [7:0] act;
        @(posedge usb_clk);
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            case (e.kind)
                0:       act = io_do;
                1:       act = {7'd0, irq_flip};
                2:       act = {7'd0, evt_empty};
                default: act = evt_dat;
            endcase
            checks++;
            if (e.due != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s: got %02h want %02h (cycle %0d, due %0d)",
                         e.name, act, e.val, cyc, e.due);
            end
        end
    end

    task automatic ex(input int kind, input logic [7:0] v, input string nm);
        exp_t e;
        e.due  = cyc + 1;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic drv(input logic rst, input logic re, input logic we,
                       input logic [5:0] a, input logic [7:0] di, input logic p);
        @(negedge usb_clk);
        usb_rst = rst; io_re = re; io_we = we; io_a = a; io_di = di; evt_re = p;
    endtask

    task automatic idle();                    drv(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0); endtask
    task automatic wr(input logic [5:0] a, input logic [7:0] d); drv(1'b0, 1'b0, 1'b1, a, d, 1'b0); endtask
    task automatic push(input logic [7:0] d); wr(6'h16, d); endtask
    task automatic pop();                     drv(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1); endtask
    task automatic rd(input logic [5:0] a, input logic [7:0] v, input string nm);
        drv(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b0);
        ex(0, v, nm);
    endtask

    task automatic idle_until(input int t);
        while (cyc + 1 - rel_cyc < t) idle();
    endtask

    initial begin
        // Reset state
        repeat (3) drv(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0);
        ex(1, 8'h00, "rst_irq"); ex(2, 8'h01, "rst_empty"); ex(0, 8'h00, "rst_io_do");
        idle(); rel_cyc = cyc;
        rd(6'h17, 8'h01, "rst_status");
        rd(6'h18, 8'h02, "rst_timer_lo");
        rd(6'h19, 8'h00, "rst_shadow");
        idle(); ex(0, 8'h00, "io_do_idle_zero");

        // Firmware IRQ toggles
        wr(6'h15, 8'hFF); ex(1, 8'h01, "irq_t1");
        repeat (3) idle();
        wr(6'h15, 8'h00); ex(1, 8'h00, "irq_t2");
        repeat (3) idle();
        wr(6'h15, 8'h5A); ex(1, 8'h01, "irq_t3"); ex(2, 8'h01, "irq_fifo_untouched");
        repeat (3) idle();

        // Auto-notify on empty push only
        push(8'hA5); ex(1, 8'h00, "auto_irq"); ex(2, 8'h00, "a5_nonempty"); ex(3, 8'hA5, "a5_head");
        repeat (3) idle();
        push(8'h3C); ex(1, 8'h00, "no_irq_nonempty"); ex(3, 8'hA5, "head_kept");
        rd(6'h17, 8'h10, "status_cnt2");
        pop(); ex(3, 8'h3C, "pop_3c");
        pop(); ex(2, 8'h01, "drained_2");

        // Overflow: 17 pushes into 16 slots
        push(8'h00); ex(1, 8'h01, "auto_irq2");
        for (int i = 1; i <= 16; i++) push(8'(i));
        rd(6'h17, 8'h86, "status_full_ovf"); ex(3, 8'h00, "head_after_fill");
        for (int i = 0; i < 16; i++) begin
            pop();
            if (i < 15) ex(3, 8'(i + 1), "pop_seq");
            else        ex(2, 8'h01, "pop_seq_empty");
        end
        rd(6'h17, 8'h05, "ovf_sticky");
        wr(6'h17, 8'h04);
        rd(6'h17, 8'h01, "ovf_cleared");

        // Full: push and pop together
        push(8'h20); ex(1, 8'h00, "auto_irq3");
        for (int i = 1; i < 16; i++) push(8'(8'h20 + i));
        drv(1'b0, 1'b0, 1'b1, 6'h16, 8'h77, 1'b1); ex(3, 8'h21, "full_pushpop_head");
        rd(6'h17, 8'h82, "full_pushpop_status");
        for (int i = 0; i < 15; i++) begin
            pop();
            ex(3, (i < 14) ? 8'(8'h22 + i) : 8'h77, "full_pushpop_seq");
        end
        pop(); ex(2, 8'h01, "full_pushpop_drained");

        // Empty: push and pop together, pop ignored
        drv(1'b0, 1'b0, 1'b1, 6'h16, 8'h55, 1'b1);
        ex(1, 8'h01, "empty_pushpop_irq"); ex(2, 8'h00, "empty_pushpop_ne"); ex(3, 8'h55, "empty_pushpop_head");
        rd(6'h17, 8'h08, "empty_pushpop_cnt1");
        pop(); ex(2, 8'h01, "empty_pushpop_drained");
        pop(); ex(2, 8'h01, "pop_when_empty");
        rd(6'h17, 8'h01, "pop_when_empty_cnt");

        // Unmapped read, then reset mid-operation
        rd(6'h20, 8'h00, "unmapped_read");
        wr(6'h15, 8'h00); ex(1, 8'h00, "pre_rst_irq");
        push(8'h99); ex(1, 8'h01, "pre_rst_push_irq"); ex(2, 8'h00, "pre_rst_ne");
        drv(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0);
        ex(1, 8'h00, "midrst_irq"); ex(2, 8'h01, "midrst_empty");
        idle(); rel_cyc = cyc;
        rd(6'h17, 8'h01, "midrst_status");

        // Timer latch and wrap
        idle_until(16'h12FF);
        rd(6'h18, 8'hFF, "timer_12ff_lo");
        repeat (5) idle();
        rd(6'h19, 8'h12, "shadow_12");
        repeat (2) idle();
        rd(6'h19, 8'h12, "shadow_12_again");
        idle_until(32'hFFFF);
        rd(6'h18, 8'hFF, "timer_ffff_lo");
        rd(6'h19, 8'hFF, "shadow_ff");
        rd(6'h18, 8'h01, "timer_wrap_lo");
        rd(6'h19, 8'h00, "shadow_wrap");
        idle();

        for (int i = 0; i < 20 && q.size() > 0; i++) idle();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
